// File: rtl/line_data_memory_if.sv
// Request/response bundle between the data-cache controller (master) and the line memory (slave).
// DMEM_RANGE_CHECK_EN adds err_o for out-of-range line addresses.
interface line_data_memory_if #(
    parameter int LINE_W = 256
);
    // enable_i is a request strobe sampled only while the memory is idle; ack_o
    // is a single-cycle completion pulse and data_o is valid from that cycle on.
    logic              enable_i;
    logic              write_i;
    logic [31:0]       addr_i;
    logic [LINE_W-1:0] data_i;
    logic [LINE_W-1:0] data_o;
    logic              ack_o;
`ifdef DMEM_RANGE_CHECK_EN
    logic              err_o;

    modport master (output enable_i, write_i, addr_i, data_i,
                    input  data_o, ack_o, err_o);
    modport slave  (input  enable_i, write_i, addr_i, data_i,
                    output data_o, ack_o, err_o);
`else
    modport master (output enable_i, write_i, addr_i, data_i,
                    input  data_o, ack_o);
    modport slave  (input  enable_i, write_i, addr_i, data_i,
                    output data_o, ack_o);
`endif
endinterface

// File: rtl/line_data_memory.sv
// Cache-line memory model with fixed request-to-ack latency and a single-cycle ack.
// DMEM_RANGE_CHECK_EN: flag (err_o) and suppress accesses above the array range.
module line_data_memory #(
    parameter int LATENCY    = 10,
    parameter int LINE_W     = 256,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                clk_i,
    input  logic                rst_i,
    line_data_memory_if.slave   bus,
    output logic [1:0]          state_o
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_e;

    localparam int         IDX_HI = DEPTH_LOG2 + 4;
    localparam logic [7:0] LAT8   = 8'(LATENCY);

    state_e                  state_q;
    logic [7:0]              cnt_q;
    logic                    write_q;
    logic [DEPTH_LOG2-1:0]   line_q;
    logic [LINE_W-1:0]       wdata_q;
    logic [LINE_W-1:0]       rdata_q;
    logic                    ack_q;
    logic                    oor_q;
    logic                    oor_in;
    logic                    done;
    logic [LINE_W-1:0]       mem_q [2**DEPTH_LOG2];

    logic unused_addr_lo;
    assign unused_addr_lo = ^bus.addr_i[4:0];

`ifdef DMEM_RANGE_CHECK_EN
    logic err_q;
    assign oor_in     = |bus.addr_i[31:IDX_HI+1];
    assign bus.err_o  = err_q;
`else
    // Upper address bits are dropped, so addresses alias onto the array.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr_i[31:IDX_HI+1];
    assign oor_in         = 1'b0;
`endif

    // cnt_q is 1 after the accepting edge, so it equals LATENCY on edge E0+LATENCY.
    assign done = (state_q == S_WAIT) && (cnt_q == LAT8);

    always_ff @(posedge clk_i) begin
        if (done && write_q && !oor_q) begin
            mem_q[line_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            write_q <= 1'b0;
            line_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            oor_q   <= 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
            err_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (bus.enable_i) begin
                        write_q <= bus.write_i;
                        line_q  <= bus.addr_i[IDX_HI:5];
                        wdata_q <= bus.data_i;
                        oor_q   <= oor_in;
                        cnt_q   <= 8'd1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (done) begin
                        state_q <= S_ACK;
                        ack_q   <= 1'b1;
`ifdef DMEM_RANGE_CHECK_EN
                        err_q   <= oor_q;
`endif
                        if (!write_q) begin
                            rdata_q <= oor_q ? '0 : mem_q[line_q];
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 8'd0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.data_o = rdata_q;
    assign bus.ack_o  = ack_q;
    assign state_o    = state_q;
endmodule

// File: tb/tb_line_data_memory.sv
// Directed bench for line_data_memory: reset, latency, capture, aliasing/range and data_o hold.
// Honours DMEM_RANGE_CHECK_EN in the same way as the design.
module tb_line_data_memory;
  localparam int LW = 256;

  logic       clk;
  logic       rst_n;
  logic [1:0] state;
  int         tests;
  int         failed;

  line_data_memory_if #(.LINE_W(LW)) bus();

  line_data_memory #(.LATENCY(10), .LINE_W(LW), .DEPTH_LOG2(9)) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .bus     (bus.slave),
    .state_o (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request from an idle FSM; returns edges from acceptance to ack and err at ack.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [LW-1:0] d,
                        output int lat, output logic err_seen);
    @(negedge clk);
    bus.enable_i = 1'b1;
    bus.write_i  = w;
    bus.addr_i   = a;
    bus.data_i   = d;
    @(posedge clk);
    #1;
    bus.enable_i = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.ack_o && lat < 40);
`ifdef DMEM_RANGE_CHECK_EN
    err_seen = bus.err_o;
`else
    err_seen = 1'b0;
`endif
    @(posedge clk);
    #1;
    chk("ack_width", {255'd0, bus.ack_o}, '0);
  endtask

  logic [LW-1:0] a_val, b_val, p2, p4, c_val, d_val, dbeef;
  int            lat;
  logic          err;
  int            acks;
  int            pos[$];

  initial begin
    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    bus.enable_i = 1'b0;
    bus.write_i  = 1'b0;
    bus.addr_i   = '0;
    bus.data_i   = '0;
    a_val = {8{32'h1111_2222}};
    b_val = {8{32'h3333_4444}};
    p2    = {8{32'h2222_0002}};
    p4    = {8{32'h4444_0004}};
    c_val = {8{32'hC0FF_EE00}};
    d_val = {8{32'h0D0D_0D0D}};
    dbeef = {8{32'hDEAD_BEEF}};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {255'd0, bus.ack_o}, '0);
    chk("rst_data", bus.data_o, '0);
    chk("rst_state", {254'd0, state}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write then read back
    do_req(1'b1, 32'h0000_0420, dbeef, lat, err);
    chk("wr_lat", lat, 10);
    chk("wr_keeps_data", bus.data_o, '0);
    do_req(1'b0, 32'h0000_0420, '0, lat, err);
    chk("rd_lat", lat, 10);
    chk("rd_data", bus.data_o, dbeef);

    // Reset mid-WAIT drops the write and clears outputs
    do_req(1'b1, 32'h0000_00E0, a_val, lat, err);
    do_req(1'b0, 32'h0000_00E0, '0, lat, err);
    chk("pre_rst_read", bus.data_o, a_val);
    @(negedge clk);
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b1;
    bus.addr_i   = 32'h0000_00E0;
    bus.data_i   = b_val;
    @(posedge clk);
    #1;
    bus.enable_i = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ack", {255'd0, bus.ack_o}, '0);
    chk("midrst_data", bus.data_o, '0);
    chk("midrst_state", {254'd0, state}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (bus.ack_o) acks++;
    end
    chk("midrst_no_ack", acks, 0);
    do_req(1'b0, 32'h0000_00E0, '0, lat, err);
    chk("midrst_write_dropped", bus.data_o, a_val);

    // Enable held high: 1-cycle acks, 12 cycles apart
    @(negedge clk);
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b0;
    bus.addr_i   = 32'h0000_0420;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (bus.ack_o) pos.push_back(e);
    end
    bus.enable_i = 1'b0;
    repeat (20) @(posedge clk);
    chk("cont_ack_count", pos.size(), 3);
    if (pos.size() >= 3) begin
      chk("cont_gap1", pos[1] - pos[0], 12);
      chk("cont_gap2", pos[2] - pos[1], 12);
      chk("cont_first", pos[0], 11);
    end
    chk("cont_data", bus.data_o, dbeef);

    // Mid-flight changes are ignored
    do_req(1'b1, 32'h0000_0040, p2, lat, err);
    do_req(1'b1, 32'h0000_0080, p4, lat, err);
    @(negedge clk);
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b0;
    bus.addr_i   = 32'h0000_0040;
    bus.data_i   = '0;
    @(posedge clk);
    #1;
    bus.addr_i   = 32'h0000_0080;
    bus.write_i  = 1'b1;
    bus.data_i   = c_val;
    repeat (5) @(posedge clk);
    #1;
    bus.enable_i = 1'b0;
    lat = 5;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.ack_o && lat < 40);
    chk("mid_lat", lat, 10);
    chk("mid_read_line2", bus.data_o, p2);
    @(posedge clk);
    do_req(1'b0, 32'h0000_0080, '0, lat, err);
    chk("mid_line4_intact", bus.data_o, p4);

    // Aliasing / range check
    do_req(1'b1, 32'h0000_0020, d_val, lat, err);
    do_req(1'b1, 32'h0000_4020, c_val, lat, err);
`ifdef DMEM_RANGE_CHECK_EN
    chk("oor_err", {255'd0, err}, 256'd1);
    chk("oor_lat", lat, 10);
    do_req(1'b0, 32'h0000_0020, '0, lat, err);
    chk("oor_line1_intact", bus.data_o, d_val);
    chk("inrange_no_err", {255'd0, err}, '0);
    do_req(1'b0, 32'h0000_4020, '0, lat, err);
    chk("oor_read_zero", bus.data_o, '0);
    chk("oor_read_err", {255'd0, err}, 256'd1);
`else
    chk("alias_lat", lat, 10);
    do_req(1'b0, 32'h0000_0020, '0, lat, err);
    chk("alias_read", bus.data_o, c_val);
`endif

    // Write does not disturb data_o
    do_req(1'b1, 32'h0000_00A0, a_val, lat, err);
    do_req(1'b0, 32'h0000_00A0, '0, lat, err);
    chk("hold_read_a", bus.data_o, a_val);
    do_req(1'b1, 32'h0000_00A0, b_val, lat, err);
    chk("hold_after_write", bus.data_o, a_val);
    repeat (5) @(posedge clk);
    #1;
    chk("hold_idle", bus.data_o, a_val);
    do_req(1'b0, 32'h0000_00A0, '0, lat, err);
    chk("hold_read_b", bus.data_o, b_val);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
